// File: rtl/psoc_audio_src_arbiter.sv
// ============================================================================
// Module   : psoc_audio_src_arbiter
// Brief    : Round-robin arbiter with burst locking. It shares the audio
//            sample FIFO write port between two 48-bit stereo sources.
//            Samples pass combinationally from the granted source to the
//            FIFO.
//            The optional per-source statistics counters are enabled by
//            defining PSOC_AUDIO_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module psoc_audio_src_arbiter #(
    parameter int BURST_LEN = 16,   // transfers per grant, 1..255
    parameter int CNT_BITS  = 32    // statistics counter width
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [47:0]         i_src0_data,
    input  logic                i_src0_valid,
    output logic                o_src0_ready,
    input  logic [47:0]         i_src1_data,
    input  logic                i_src1_valid,
    output logic                o_src1_ready,
    input  logic [1:0]          i_src_enable,
    output logic [47:0]         o_fifo_data,
    output logic                o_fifo_write,
    input  logic                i_fifo_ready,
    output logic [1:0]          o_grant,
    output logic                o_busy,
    input  logic                i_clear_stats,
    output logic [CNT_BITS-1:0] o_src0_count,
    output logic [CNT_BITS-1:0] o_src1_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT0 = 2'd1;
    localparam logic [1:0] S_GNT1 = 2'd2;

    // Value of the burst counter on the final transfer of a burst
    localparam logic [7:0] c_BURST_LAST = 8'(BURST_LEN - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [1:0] w_other_state;
    logic [7:0] r_burst_cnt;
    logic       r_last_grant;   // 0: src0 last held the grant, 1: src1
    logic       w_req0;
    logic       w_req1;
    logic       w_req_own;
    logic       w_req_other;
    logic       w_xfer;
    logic       w_burst_end;
    logic       w_exit;

    assign w_req0 = i_src0_valid & i_src_enable[0];
    assign w_req1 = i_src1_valid & i_src_enable[1];

    // Select the request of the granted source and of the competing source
    always_comb begin
        w_req_own     = 1'b0;
        w_req_other   = 1'b0;
        w_other_state = S_IDLE;
        case (r_state)
            S_GNT0: begin
                w_req_own     = w_req0;
                w_req_other   = w_req1;
                w_other_state = S_GNT1;
            end
            S_GNT1: begin
                w_req_own     = w_req1;
                w_req_other   = w_req0;
                w_other_state = S_GNT0;
            end
            default: begin
                w_req_own     = 1'b0;
                w_req_other   = 1'b0;
                w_other_state = S_IDLE;
            end
        endcase
    end

    assign w_xfer      = w_req_own & i_fifo_ready;
    assign w_burst_end = w_xfer & (r_burst_cnt == c_BURST_LAST);
    // A dropped request releases the grant even if the burst would also end
    assign w_exit      = (r_state != S_IDLE) & (~w_req_own | w_burst_end);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection: round-robin from idle, hand-over at burst end or release
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next_state = r_last_grant ? S_GNT0 : S_GNT1;
                end else if (w_req0) begin
                    w_next_state = S_GNT0;
                end else if (w_req1) begin
                    w_next_state = S_GNT1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_GNT0, S_GNT1: begin
                if (w_exit) begin
                    if (w_req_other) begin
                        w_next_state = w_other_state;
                    end else if (w_req_own) begin
                        w_next_state = r_state;   // fresh burst, same source
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: grant from state, zero-latency pass-through of the granted source
    always_comb begin
        o_grant      = 2'b00;
        o_busy       = 1'b0;
        o_fifo_data  = 48'd0;
        o_fifo_write = w_xfer;
        o_src0_ready = 1'b0;
        o_src1_ready = 1'b0;
        case (r_state)
            S_GNT0: begin
                o_grant      = 2'b01;
                o_busy       = 1'b1;
                o_fifo_data  = i_src0_data;
                o_src0_ready = w_xfer;
            end
            S_GNT1: begin
                o_grant      = 2'b10;
                o_busy       = 1'b1;
                o_fifo_data  = i_src1_data;
                o_src1_ready = w_xfer;
            end
            default: begin
                o_grant      = 2'b00;
                o_busy       = 1'b0;
                o_fifo_data  = 48'd0;
            end
        endcase
    end

    // Burst length counter; restarts whenever the current grant is given up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= 8'd0;
        end else if (w_exit) begin
            r_burst_cnt <= 8'd0;
        end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
        end
    end

    // Remember who was served last so the next tie goes to the other source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_next_state == S_GNT0) begin
            r_last_grant <= 1'b0;
        end else if (w_next_state == S_GNT1) begin
            r_last_grant <= 1'b1;
        end
    end

`ifdef PSOC_AUDIO_ARB_STATS_EN
    logic [CNT_BITS-1:0] r_src0_count;
    logic [CNT_BITS-1:0] r_src1_count;

    // Accepted-sample counters; a clear in the same cycle as a transfer wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src0_count <= '0;
            r_src1_count <= '0;
        end else if (i_clear_stats) begin
            r_src0_count <= '0;
            r_src1_count <= '0;
        end else begin
            if (o_src0_ready) begin
                r_src0_count <= r_src0_count + 1'b1;
            end
            if (o_src1_ready) begin
                r_src1_count <= r_src1_count + 1'b1;
            end
        end
    end

    assign o_src0_count = r_src0_count;
    assign o_src1_count = r_src1_count;
`else
    logic w_unused_clear_stats;

    assign w_unused_clear_stats = i_clear_stats;
    assign o_src0_count         = '0;
    assign o_src1_count         = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_psoc_audio_src_arbiter.sv
// ============================================================================
// Module   : tb_psoc_audio_src_arbiter
// Brief    : Self-checking bench for psoc_audio_src_arbiter (BURST_LEN=4).
//            Directed scenarios are followed by a randomized phase. All of
//            them are checked against a cycle-level reference model of the
//            arbitration rules.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_psoc_audio_src_arbiter;

    localparam int BL = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [47:0]   s0d, s1d, fd;
    logic          s0v, s1v, s0r, s1r, fw, fr, busy, clr;
    logic [1:0]    en, gr;
    logic [CW-1:0] c0, c1;

    int errors = 0;
    int checks = 0;

    // Reference model state: owner -1 idle, else source index
    int          m_owner, m_cnt, m_last;
    logic [31:0] m_c0, m_c1;
    logic        m_acc0, m_acc1;
    int          q_wr[$];

    always #5 clk = ~clk;

    psoc_audio_src_arbiter #(.BURST_LEN(BL), .CNT_BITS(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_src0_data   (s0d),
        .i_src0_valid  (s0v),
        .o_src0_ready  (s0r),
        .i_src1_data   (s1d),
        .i_src1_valid  (s1v),
        .o_src1_ready  (s1r),
        .i_src_enable  (en),
        .o_fifo_data   (fd),
        .o_fifo_write  (fw),
        .i_fifo_ready  (fr),
        .o_grant       (gr),
        .o_busy        (busy),
        .i_clear_stats (clr),
        .o_src0_count  (c0),
        .o_src1_count  (c1)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_last = 1;
        m_c0 = 0; m_c1 = 0; m_acc0 = 0; m_acc1 = 0;
    endtask

    task automatic do_reset();
        s0v = 0; s1v = 0; en = 2'b11; fr = 1; clr = 0;
        s0d = 48'h000A00_000B00; s1d = 48'h111100_222200;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model
    task automatic cycle();
        logic r[2];
        logic x;
        int   nx;
        logic [1:0]  e_gr;
        logic [47:0] e_fd;
        @(negedge clk);
        r[0] = s0v & en[0];
        r[1] = s1v & en[1];
        x    = (m_owner >= 0) ? (r[m_owner] & fr) : 1'b0;
        e_gr = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        e_fd = (m_owner == 0) ? s0d : (m_owner == 1) ? s1d : 48'd0;
        chk("grant", {46'd0, gr}, {46'd0, e_gr});
        chk("busy", {47'd0, busy}, {47'd0, (m_owner >= 0)});
        chk("fifo_write", {47'd0, fw}, {47'd0, x});
        chk("fifo_data", fd, e_fd);
        chk("src0_ready", {47'd0, s0r}, {47'd0, (x && m_owner == 0)});
        chk("src1_ready", {47'd0, s1r}, {47'd0, (x && m_owner == 1)});
`ifdef PSOC_AUDIO_ARB_STATS_EN
        chk("src0_count", {16'd0, c0}, {16'd0, m_c0});
        chk("src1_count", {16'd0, c1}, {16'd0, m_c1});
`else
        chk("src0_count", {16'd0, c0}, 48'd0);
        chk("src1_count", {16'd0, c1}, 48'd0);
`endif
        if (fw) q_wr.push_back((gr == 2'b10) ? 1 : 0);
        m_acc0 = x && (m_owner == 0);
        m_acc1 = x && (m_owner == 1);
        if (clr) begin
            m_c0 = 0; m_c1 = 0;
        end else begin
            if (m_acc0) m_c0 = m_c0 + 1;
            if (m_acc1) m_c1 = m_c1 + 1;
        end
        // Arbitration rules
        if (m_owner < 0) begin
            if (r[0] && r[1]) nx = 1 - m_last;
            else if (r[0])    nx = 0;
            else if (r[1])    nx = 1;
            else              nx = -1;
        end else begin
            nx = m_owner;
            if (!r[m_owner]) begin
                nx = r[1 - m_owner] ? 1 - m_owner : -1;
                m_cnt = 0;
            end else if (x) begin
                m_cnt++;
                if (m_cnt == BL) begin
                    m_cnt = 0;
                    nx = r[1 - m_owner] ? 1 - m_owner : m_owner;
                end
            end
        end
        m_owner = nx;
        if (nx >= 0) m_last = nx;
        @(posedge clk);
        #1;
        // Sources present the next sample once the current one was taken
        if (m_acc0) s0d = s0d + 48'd1;
        if (m_acc1) s1d = s1d + 48'd1;
    endtask

    task automatic rnd_inputs();
        logic [63:0] v;
        if (!s0v || m_acc0) begin
            v = {$urandom, $urandom};
            s0d = v[47:0];
            s0v = ($urandom_range(0, 3) != 0);
        end
        if (!s1v || m_acc1) begin
            v = {$urandom, $urandom};
            s1d = v[47:0];
            s1v = ($urandom_range(0, 3) != 0);
        end
        if ($urandom_range(0, 15) == 0) en = 2'($urandom_range(0, 3));
        fr  = ($urandom_range(0, 4) != 0);
        clr = ($urandom_range(0, 40) == 0);
    endtask

    initial begin
        // 1: single source, back-to-back bursts with no gap
        do_reset();
        chk("reset_grant", {46'd0, gr}, 48'd0);
        chk("reset_write", {47'd0, fw}, 48'd0);
        s0v = 1;
        q_wr.delete();
        repeat (9) cycle();
        chk("solo_writes", 48'(q_wr.size()), 48'd8);

        // 2: both sources continuously valid -> 4/4 alternation
        do_reset();
        s0v = 1; s1v = 1;
        q_wr.delete();
        repeat (17) cycle();
        chk("alt_writes", 48'(q_wr.size()), 48'd16);
        for (int i = 0; i < q_wr.size(); i++)
            chk("alt_order", 48'(q_wr[i]), 48'((i / BL) % 2));

        // 3: FIFO stall after 2 transfers holds grant and burst position
        do_reset();
        s0v = 1; s1v = 1;
        repeat (3) cycle();
        fr = 0;
        repeat (5) cycle();
        fr = 1;
        repeat (2) cycle();
        cycle();
        chk("stall_switch", {46'd0, gr}, 48'd2);

        // 4: disabling src1 mid-burst releases to src0
        do_reset();
        s0v = 1; s1v = 1;
        repeat (6) cycle();
        en = 2'b01;
        cycle();
        cycle();
        chk("disable_release", {46'd0, gr}, 48'd1);

        // 5: asynchronous reset between clock edges
        en = 2'b11;
        repeat (2) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", {46'd0, gr}, 48'd0);
        chk("async_rst_write", {47'd0, fw}, 48'd0);
        s0v = 0; s1v = 0;
        model_reset();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        s0v = 1; s1v = 1;
        cycle();
        cycle();
        chk("post_rst_tie", {46'd0, gr}, 48'd1);

        // 6: statistics 10/7 then clear
        do_reset();
        s0v = 1;
        repeat (11) cycle();
        s0v = 0; s1v = 1;
        repeat (8) cycle();
        s1v = 0;
        cycle();
`ifdef PSOC_AUDIO_ARB_STATS_EN
        chk("stats_c0", {16'd0, c0}, 48'd10);
        chk("stats_c1", {16'd0, c1}, 48'd7);
`else
        chk("stats_c0", {16'd0, c0}, 48'd0);
        chk("stats_c1", {16'd0, c1}, 48'd0);
`endif
        clr = 1;
        cycle();
        clr = 0;
        cycle();
        chk("clear_c0", {16'd0, c0}, 48'd0);
        chk("clear_c1", {16'd0, c1}, 48'd0);

        // 7: randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            rnd_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/psoc_audio_src_arbiter.md
Name: psoc_audio_src_arbiter

Overview:
- Shares the audio sample FIFO write port between two sample sources: src0 (software/Wishbone register path) and src1 (DMA or tone engine).
- Round-robin arbitration with burst locking. Each 48-bit stereo word (L/R 24-bit each) passes straight through to the FIFO write port while its source holds the grant.
- Sits between the register file / sample producers and the sfifo write side inside the audio IP.

Parameters:
- BURST_LEN, 16: maximum transfers per grant before the arbiter re-arbitrates; legal range 1..255.
- CNT_BITS, 32: width of the per-source statistics counters (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- src0_data  in  48  source 0 sample {L[23:0], R[23:0]}
- src0_valid  in  1  source 0 has a sample
- src0_ready  out  1  source 0 sample accepted this cycle
- src1_data  in  48  source 1 sample
- src1_valid  in  1  source 1 has a sample
- src1_ready  out  1  source 1 sample accepted this cycle
- src_enable  in  2  per-source enable; bit n gates source n
- fifo_data  out  48  sample to FIFO write port
- fifo_write  out  1  FIFO write strobe
- fifo_ready  in  1  FIFO can accept (not full)
- grant  out  2  one-hot current grant; 00 when idle
- busy  out  1  grant active
- clear_stats  in  1  synchronous clear of the statistics counters
- src0_count  out  CNT_BITS  samples accepted from src0
- src1_count  out  CNT_BITS  samples accepted from src1

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, burst_cnt=0, last_grant=1 (so src0 wins the first tie), grant=00, busy=0, fifo_write=0, srcN_ready=0, counters=0.
- req_n = srcN_valid & src_enable[n].
- States are IDLE, GNT0 and GNT1. grant/busy decode from the state register.
- IDLE:
  - req0 only -> GNT0.
  - req1 only -> GNT1.
  - Both -> the source other than last_grant.
  - Neither -> stay in IDLE.
  - No transfer happens in IDLE, so first-sample latency is 1 cycle from valid.
- In GNTn:
  - Transfer condition: xfer = req_n & fifo_ready. This is combinational, with zero-latency pass-through.
  - srcN_ready = xfer.
  - fifo_write = xfer.
  - fifo_data = srcN_data while in GNTn; 0 in IDLE.
  - The other source's ready is 0.
  - Each xfer increments burst_cnt. last_grant=n is latched on entering GNTn.
- Leaving GNTn:
  - (a) xfer with burst_cnt==BURST_LEN-1 (burst end).
  - (b) req_n low (valid dropped or source disabled). This takes priority over (a) when both hold.
  - On exit burst_cnt resets to 0.
  - Next state on (a):
    - Other source requesting -> GNT(other) directly, with no IDLE bubble.
    - Else, if req_n is still high -> GNTn again with a fresh burst.
    - Else -> IDLE.
  - Next state on (b): other source requesting -> GNT(other); else IDLE.
- fifo_ready low in GNTn:
  - No transfer; grant and burst_cnt hold.
  - There is no timeout; the FIFO is always eventually drained by I2S/DAC.
- Disable mid-burst: src_enable[n] falling drops req_n in the same cycle. No transfer occurs that cycle, and the block releases per (b).
- Simultaneous burst end and the other source asserting valid in that same cycle: the switch happens (other wins).
- BURST_LEN=1 degenerates to strict per-sample alternation when both sources request.
- Sources must keep data stable while valid & !ready. The arbiter does not buffer.

Optional Feature:
- Macro: PSOC_AUDIO_ARB_STATS_EN.
- Defined:
  - srcN_count increments on each srcN transfer and wraps modulo 2^CNT_BITS.
  - clear_stats zeroes both counters next cycle. A transfer in the same cycle is lost (clear wins).
- Undefined:
  - Counters are not instantiated; src0_count and src1_count are tied to 0.
  - clear_stats is ignored.
  - Arbitration is unaffected.

Test Plan:
- Reset, then src0_valid=1 only, enable=11, fifo_ready=1, BURST_LEN=4 -> grant=01 after 1 cycle; 4 transfers; re-grant to src0 with a 0-cycle gap; fifo_data equals the src0 sequence.
- Both sources valid continuously, BURST_LEN=4 -> first grant src0. Write sequence: 4×src0, 4×src1, 4×src0..., with no idle cycles at switches.
- fifo_ready=0 for 5 cycles mid-burst after 2 transfers -> no writes, grant held, burst_cnt=2. After ready returns, 2 more transfers, then switch.
- In GNT1 after 1 transfer, drop src_enable[1] while src0 is valid -> src1_ready=0 that cycle; next cycle grant=01.
- Assert rst_n low asynchronously mid-burst (between clock edges) -> grant=00 and fifo_write=0 immediately. After release, src0 wins the tie.
- With PSOC_AUDIO_ARB_STATS_EN: 10 src0 and 7 src1 transfers -> counts 10/7. Pulse clear_stats -> 0/0. Without the macro, both counts read 0 throughout.
